// File: rtl/spi_slave_if_if.sv
// SPI slave bus bundle for spi_slave_if.
// Groups the SPI pins (ss_n/mosi/miso) with the RAM-side command and read
// data strobes so the slave and its environment share one connection.
//
// Strobe semantics (there is no ready/backpressure on either strobe):
//   rx_valid : one-clk pulse; rx_data is meaningful only in that cycle and
//              holds its last value otherwise. The RAM must accept it.
//   tx_valid : one-clk pulse from the RAM qualifying tx_data. The slave
//              consumes it only while waiting for read data in READ_DATA,
//              and ignores it in every other cycle.
//   cmd_err  : one-clk pulse reporting a command/branch mismatch; it is
//              always 0 when command checking is not built in.
interface spi_slave_if_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 ss_n;
  logic                 mosi;
  logic                 miso;
  logic [ADDR_SIZE+1:0] rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] tx_data;
  logic                 tx_valid;
  logic                 cmd_err;

  // The SPI slave block itself.
  modport slave (
    input  ss_n,
    input  mosi,
    input  tx_data,
    input  tx_valid,
    output miso,
    output rx_data,
    output rx_valid,
    output cmd_err
  );

  // The SPI master plus RAM environment driving the slave.
  modport master (
    output ss_n,
    output mosi,
    output tx_data,
    output tx_valid,
    input  miso,
    input  rx_data,
    input  rx_valid,
    input  cmd_err
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port RAM.
// One SPI bit per rising clk edge while ss_n is low; MOSI/MISO are MSB first.
// A frame is a (ADDR_SIZE+2)-bit command word: the first bit selects write
// (0) or read (1); a read goes to READ_ADD unless a read address has already
// been received, in which case it goes to READ_DATA and the RAM's read data
// is shifted back out on MISO.
//
// Optional build macro: SPI_CMD_CHECK_EN
//   defined   : the opcode bits of each completed frame are checked against
//               the branch taken; a mismatch raises cmd_err for one clk
//               instead of rx_valid and leaves rd_addr_rcvd untouched.
//   undefined : cmd_err stays 0 and every completed frame is forwarded.
//
// dbg_state / dbg_rd_addr_rcvd expose the FSM state and the read-address
// flag for observation; they have no functional role.
module spi_slave_if #(
  parameter int ADDR_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_slave_if_if.slave     bus,
  output logic [2:0]        dbg_state,
  output logic              dbg_rd_addr_rcvd
);

  localparam int W  = ADDR_SIZE + 2;          // command word width
  localparam int CW = $clog2(W + 1);          // bit counter holds 0..W
  localparam int TW = $clog2(ADDR_SIZE + 1);  // MISO bits-remaining counter

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  state_e               state_q, state_d;
  // Only the W-1 already-received bits need storing; the bit arriving on the
  // current edge is appended combinationally to form the full word.
  logic [W-2:0]         shift_q, shift_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [W-1:0]         rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 rd_addr_rcvd_q, rd_addr_rcvd_d;
  logic                 miso_q, miso_d;
  logic [ADDR_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic [TW-1:0]        tx_cnt_q, tx_cnt_d;
  logic                 tx_busy_q, tx_busy_d;   // MISO phase in progress
  logic                 tx_done_q, tx_done_d;   // MISO phase finished or skipped

  logic [W-1:0]         word_full;   // received word including this edge's bit
  logic                 last_bit;    // this edge samples bit 0 of the frame
  logic                 frame_done;  // all W bits of the frame received
  logic                 cmd_ok;      // opcode agrees with the branch taken

  assign word_full  = {shift_q, bus.mosi};
  assign last_bit   = (bit_cnt_q == CW'(W - 1));
  assign frame_done = (bit_cnt_q == CW'(W));

`ifdef SPI_CMD_CHECK_EN
  // Opcode check: a write accepts either data/address opcode, each read
  // branch demands its own opcode.
  always_comb begin
    cmd_ok = 1'b1;
    case (state_q)
      READ_ADD:  cmd_ok = (word_full[W-1:W-2] == 2'b10);
      READ_DATA: cmd_ok = (word_full[W-1:W-2] == 2'b11);
      default:   cmd_ok = 1'b1;
    endcase
  end
`else
  assign cmd_ok = 1'b1;
`endif

  // Next-state logic for the FSM, the MOSI deserialiser and the MISO serialiser.
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    cmd_err_d      = 1'b0;
    rd_addr_rcvd_d = rd_addr_rcvd_q;
    miso_d         = miso_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;
    tx_busy_d      = tx_busy_q;
    tx_done_d      = tx_done_q;

    if ((state_q != IDLE) && bus.ss_n) begin
      // Deselect ends any frame: drop everything in flight. rd_addr_rcvd is
      // kept so an aborted read-data frame can be retried.
      state_d    = IDLE;
      shift_d    = '0;
      bit_cnt_d  = '0;
      miso_d     = 1'b0;
      tx_shift_d = '0;
      tx_cnt_d   = '0;
      tx_busy_d  = 1'b0;
      tx_done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.ss_n) begin
            state_d   = CHK_CMD;
            shift_d   = '0;
            bit_cnt_d = '0;
          end
        end

        CHK_CMD: begin
          // First frame bit chooses the branch.
          shift_d   = word_full[W-2:0];
          bit_cnt_d = CW'(1);
          if (!bus.mosi) begin
            state_d = WRITE;
          end else if (rd_addr_rcvd_q) begin
            state_d = READ_DATA;
          end else begin
            state_d = READ_ADD;
          end
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (!frame_done) begin
            shift_d   = word_full[W-2:0];
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (last_bit) begin
              if (cmd_ok) begin
                rx_data_d  = word_full;
                rx_valid_d = 1'b1;
                if (state_q == READ_ADD) begin
                  rd_addr_rcvd_d = 1'b1;
                end
              end else begin
                // Rejected frame: nothing forwarded, no read data phase.
                cmd_err_d = 1'b1;
                if (state_q == READ_DATA) begin
                  tx_done_d = 1'b1;
                end
              end
            end
          end else if (state_q == READ_DATA) begin
            if (tx_busy_q) begin
              if (tx_cnt_q != '0) begin
                miso_d     = tx_shift_q[ADDR_SIZE-1];
                tx_shift_d = {tx_shift_q[ADDR_SIZE-2:0], 1'b0};
                tx_cnt_d   = tx_cnt_q - TW'(1);
              end else begin
                // Last bit has been on MISO for a full clk: read completes.
                miso_d         = 1'b0;
                tx_busy_d      = 1'b0;
                tx_done_d      = 1'b1;
                rd_addr_rcvd_d = 1'b0;
              end
            end else if (!tx_done_q && bus.tx_valid) begin
              // Capture read data; its MSB goes out right away.
              miso_d     = bus.tx_data[ADDR_SIZE-1];
              tx_shift_d = {bus.tx_data[ADDR_SIZE-2:0], 1'b0};
              tx_cnt_d   = TW'(ADDR_SIZE - 1);
              tx_busy_d  = 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      cmd_err_q      <= 1'b0;
      rd_addr_rcvd_q <= 1'b0;
      miso_q         <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      tx_busy_q      <= 1'b0;
      tx_done_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      cmd_err_q      <= cmd_err_d;
      rd_addr_rcvd_q <= rd_addr_rcvd_d;
      miso_q         <= miso_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_busy_q      <= tx_busy_d;
      tx_done_q      <= tx_done_d;
    end
  end

  assign bus.miso         = miso_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.cmd_err      = cmd_err_q;
  assign dbg_state        = state_q;
  assign dbg_rd_addr_rcvd = rd_addr_rcvd_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed testbench for spi_slave_if: write address/data, read address then
// read data with a RAM reply, abort, reset during MISO shift, command check.
module tb_spi_slave_if;

  localparam int AS = 8;
  localparam int W  = AS + 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CHK  = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_RADD = 3'd3;
  localparam logic [2:0] S_RDAT = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;
  logic       dbg_rd_addr_rcvd;

  int   checks   = 0;
  int   failures = 0;
  int   rv_cnt;
  int   rv_at;
  int   ce_cnt;
  logic miso_hi;
  logic [7:0] rd_byte;

  spi_slave_if_if #(.ADDR_SIZE(AS)) bus ();

  spi_slave_if #(.ADDR_SIZE(AS)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .dbg_state        (dbg_state),
    .dbg_rd_addr_rcvd (dbg_rd_addr_rcvd)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clk; sample and drive 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive bits [W-1-first .. W-first-n] of w, one per clk, recording the
  // strobes and whether miso ever went high.
  task automatic shift_bits(input logic [W-1:0] w, input int first, input int n);
    rv_cnt  = 0;
    rv_at   = -1;
    ce_cnt  = 0;
    miso_hi = 1'b0;
    for (int i = first; i < first + n; i++) begin
      bus.mosi = w[W-1-i];
      tick();
      if (bus.rx_valid) begin
        rv_cnt++;
        rv_at = i;
      end
      if (bus.cmd_err) ce_cnt++;
      if (bus.miso) miso_hi = 1'b1;
    end
    bus.mosi = 1'b0;
  endtask

  task automatic start_frame();
    bus.ss_n = 1'b0;
    tick();
  endtask

  task automatic end_frame();
    bus.ss_n = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.ss_n = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.ss_n     = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    rst_n        = 1'b0;
    tick();
    tick();

    // reset values
    chk("rst_miso",     32'(bus.miso),         32'd0);
    chk("rst_rx_data",  32'(bus.rx_data),      32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid),     32'd0);
    chk("rst_cmd_err",  32'(bus.cmd_err),      32'd0);
    chk("rst_state",    32'(dbg_state),        32'(S_IDLE));
    chk("rst_rd_addr",  32'(dbg_rd_addr_rcvd), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_hold", 32'(dbg_state), 32'(S_IDLE));

    // write address 00_0000_0101, stray tx_valid must not reach miso
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b1;
    start_frame();
    chk("wa_chk_cmd", 32'(dbg_state), 32'(S_CHK));
    shift_bits(10'h005, 0, W);
    bus.tx_valid = 1'b0;
    chk("wa_rv_cnt",  32'(rv_cnt),      32'd1);
    chk("wa_rv_at",   32'(rv_at),       32'd9);
    chk("wa_rx_data", 32'(bus.rx_data), 32'h005);
    chk("wa_miso",    32'(miso_hi),     32'd0);
    chk("wa_state",   32'(dbg_state),   32'(S_WR));
    end_frame();
    chk("wa_idle",    32'(dbg_state),    32'(S_IDLE));
    chk("wa_rv_low",  32'(bus.rx_valid), 32'd0);

    // write data 01_1010_1010, then extra clks stay in WRITE with no strobe
    start_frame();
    shift_bits(10'h1AA, 0, W);
    chk("wd_rv_cnt",  32'(rv_cnt),      32'd1);
    chk("wd_rx_data", 32'(bus.rx_data), 32'h1AA);
    shift_bits(10'h3FF, 0, 3);
    chk("wd_extra_rv", 32'(rv_cnt),      32'd0);
    chk("wd_state",    32'(dbg_state),   32'(S_WR));
    chk("wd_hold",     32'(bus.rx_data), 32'h1AA);
    end_frame();

    // read address 10_0000_0101
    start_frame();
    shift_bits(10'h205, 0, W);
    chk("ra_rv_cnt",  32'(rv_cnt),           32'd1);
    chk("ra_rx_data", 32'(bus.rx_data),      32'h205);
    chk("ra_state",   32'(dbg_state),        32'(S_RADD));
    chk("ra_flag",    32'(dbg_rd_addr_rcvd), 32'd1);
    end_frame();
    chk("ra_flag_kept", 32'(dbg_rd_addr_rcvd), 32'd1);

    // read data 11_1100_0011, RAM answers 8'hAA one clk after rx_valid
    start_frame();
    shift_bits(10'h3C3, 0, W);
    chk("rd_rv_cnt",  32'(rv_cnt),      32'd1);
    chk("rd_rx_data", 32'(bus.rx_data), 32'h3C3);
    chk("rd_state",   32'(dbg_state),   32'(S_RDAT));
    bus.tx_data  = 8'hAA;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    rd_byte[7] = bus.miso;
    for (int i = 6; i >= 0; i--) begin
      tick();
      rd_byte[i] = bus.miso;
    end
    chk("rd_miso_byte", 32'(rd_byte), 32'hAA);
    tick();
    chk("rd_miso_after", 32'(bus.miso),         32'd0);
    chk("rd_flag_clr",   32'(dbg_rd_addr_rcvd), 32'd0);
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    chk("rd_late_txv", 32'(bus.miso), 32'd0);
    tick();
    chk("rd_late_txv2", 32'(bus.miso), 32'd0);
    chk("rd_state_end", 32'(dbg_state), 32'(S_RDAT));
    end_frame();
    chk("rd_idle", 32'(dbg_state), 32'(S_IDLE));

    // abort a write after 5 bits, then a full frame decodes normally
    start_frame();
    shift_bits(10'h0F0, 0, 5);
    chk("ab_rv_cnt", 32'(rv_cnt), 32'd0);
    end_frame();
    chk("ab_idle",   32'(dbg_state),    32'(S_IDLE));
    chk("ab_rv_low", 32'(bus.rx_valid), 32'd0);
    start_frame();
    shift_bits(10'h0F0, 0, W);
    chk("ab_next_rv_at", 32'(rv_at),       32'd9);
    chk("ab_next_data",  32'(bus.rx_data), 32'h0F0);
    end_frame();

    // READ_ADD branch receiving opcode 11
    start_frame();
    shift_bits(10'h301, 0, W);
    chk("cc_state", 32'(dbg_state), 32'(S_RADD));
`ifdef SPI_CMD_CHECK_EN
    chk("cc_cmd_err", 32'(ce_cnt),           32'd1);
    chk("cc_rv_cnt",  32'(rv_cnt),           32'd0);
    chk("cc_flag",    32'(dbg_rd_addr_rcvd), 32'd0);
    chk("cc_hold",    32'(bus.rx_data),      32'h0F0);
`else
    chk("cc_cmd_err", 32'(ce_cnt),           32'd0);
    chk("cc_rv_cnt",  32'(rv_cnt),           32'd1);
    chk("cc_flag",    32'(dbg_rd_addr_rcvd), 32'd1);
    chk("cc_rx_data", 32'(bus.rx_data),      32'h301);
`endif
    end_frame();

    // reset in the middle of the MISO shift
    do_reset();
    chk("rr_pre_flag", 32'(dbg_rd_addr_rcvd), 32'd0);
    start_frame();
    shift_bits(10'h210, 0, W);
    chk("rr_ra_flag", 32'(dbg_rd_addr_rcvd), 32'd1);
    end_frame();
    start_frame();
    shift_bits(10'h300, 0, W);
    bus.tx_data  = 8'hAA;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    tick();
    tick();
    chk("rr_mid_miso", 32'(bus.miso), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rr_miso",  32'(bus.miso),         32'd0);
    chk("rr_state", 32'(dbg_state),        32'(S_IDLE));
    chk("rr_flag",  32'(dbg_rd_addr_rcvd), 32'd0);
    chk("rr_rv",    32'(bus.rx_valid),     32'd0);
    rst_n    = 1'b1;
    bus.ss_n = 1'b1;
    tick();
    start_frame();
    shift_bits(10'h2AB, 0, 1);
    chk("rr_next_state", 32'(dbg_state), 32'(S_RADD));
    shift_bits(10'h2AB, 1, W - 1);
    chk("rr_next_rv_at", 32'(rv_at),            32'd9);
    chk("rr_next_data",  32'(bus.rx_data),      32'h2AB);
    chk("rr_next_flag",  32'(dbg_rd_addr_rcvd), 32'd1);
    end_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
